// File: rtl/load_store_unit.sv
// load_store_unit
// Sits between the pipeline MEM stage and a word-addressed data memory.
// It converts RISC-V byte-addressed loads and stores (lb/lh/lw/lbu/lhu and
// sb/sh/sw) into whole-word memory accesses.
//
// Sub-word stores are done as a read-modify-write. In the first cycle the
// word is read and merged, and the pipeline is stalled. In the second cycle
// the merged word is written. Load results come out one cycle after the
// request, and are registered. Misaligned and out-of-range accesses never
// reach the memory. Instead they raise a one-cycle flag.
//
// Ports
//   clk          : clock; all state changes on its rising edge
//   reset        : synchronous, active-low reset
//   req_valid    : MEM stage presents a memory instruction
//   req_write    : 1 = store, 0 = load
//   req_funct3   : RISC-V funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   req_addr     : byte address
//   req_wdata    : store data (low byte/half used for sb/sh)
//   stall        : combinational; pipeline must hold the MEM-stage request
//   load_data    : registered, sign/zero-extended load result
//   load_valid   : one-cycle pulse qualifying load_data
//   misaligned   : one-cycle pulse, access blocked for misalignment
//   out_of_range : one-cycle pulse, word index >= DEPTH
//   mem_addr     : word index presented to the memory
//   mem_wdata    : word to write
//   mem_wen      : write strobe (memory writes on the rising edge)
//   mem_ren      : read enable (memory answers combinationally on mem_rdata)
//   mem_rdata    : word read from memory
module load_store_unit #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        out_of_range,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic        mem_ren,
  input  logic [31:0] mem_rdata
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] RMW_WRITE = 1'b1;

  // One extra bit so the limit can be compared against a full 30-bit index.
  localparam logic [30:0] DEPTH_LIMIT = 31'(DEPTH);

  logic [0:0]  state;
  logic [31:0] rmw_word;
  logic [29:0] rmw_index;

  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        legal;
  logic        mis_c;
  logic        oor_c;
  logic        accept;
  logic        subword_store;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Decode the request.
  // "accept" means the access is legal, aligned and in range, so it may
  // actually reach the memory in this cycle.
  always_comb begin
    is_byte = (req_funct3[1:0] == 2'b00);
    is_half = (req_funct3[1:0] == 2'b01);
    is_word = (req_funct3[1:0] == 2'b10);

    if (req_write)
      legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
              (req_funct3 == 3'b010);
    else
      legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
              (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
              (req_funct3 == 3'b101);

    mis_c = legal && ((is_half && req_addr[0]) ||
                      (is_word && (req_addr[1:0] != 2'b00)));

    // Misalignment wins, so range is only flagged for aligned requests.
    oor_c = legal && !mis_c && ({1'b0, req_addr[31:2]} >= DEPTH_LIMIT);

    subword_store = req_write && !is_word;
    accept = reset && (state == IDLE) && req_valid && legal && !mis_c && !oor_c;
  end

  // Memory-side and pipeline-side strobes.
  // In RMW_WRITE the held index and merged word drive the memory. The
  // incoming request is ignored there, because it is the same store still
  // being held by the pipeline.
  always_comb begin
    stall   = accept && subword_store;
    mem_ren = accept && (!req_write || subword_store);
    mem_wen = reset && ((state == RMW_WRITE) || (accept && req_write && is_word));
    if (state == RMW_WRITE) begin
      mem_addr  = {2'b00, rmw_index};
      mem_wdata = rmw_word;
    end else begin
      mem_addr  = {2'b00, req_addr[31:2]};
      mem_wdata = req_wdata;
    end
  end

  // Lane selection and extension for loads.
  // Also builds the merged word for sub-word stores.
  always_comb begin
    case (req_addr[1:0])
      2'b00:   byte_lane = mem_rdata[7:0];
      2'b01:   byte_lane = mem_rdata[15:8];
      2'b10:   byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (req_funct3)
      3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_ext = {24'b0, byte_lane};
      3'b101:  load_ext = {16'b0, half_lane};
      default: load_ext = mem_rdata;
    endcase

    merged = mem_rdata;
    if (is_byte) begin
      case (req_addr[1:0])
        2'b00:   merged[7:0]   = req_wdata[7:0];
        2'b01:   merged[15:8]  = req_wdata[7:0];
        2'b10:   merged[23:16] = req_wdata[7:0];
        default: merged[31:24] = req_wdata[7:0];
      endcase
    end else if (req_addr[1]) begin
      merged[31:16] = req_wdata[15:0];
    end else begin
      merged[15:0] = req_wdata[15:0];
    end
  end

  // FSM and registered outputs.
  // The flags are single-cycle pulses, so they clear by default every cycle.
  // A blocked load still completes, with zero data, so the pipeline always
  // gets a load_valid for each load it issues.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      load_data    <= '0;
      load_valid   <= 1'b0;
      misaligned   <= 1'b0;
      out_of_range <= 1'b0;
      rmw_word     <= '0;
      rmw_index    <= '0;
    end else begin
      load_valid   <= 1'b0;
      misaligned   <= 1'b0;
      out_of_range <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && legal) begin
            if (mis_c || oor_c) begin
              misaligned   <= mis_c;
              out_of_range <= oor_c;
              if (!req_write) begin
                load_valid <= 1'b1;
                load_data  <= '0;
              end
            end else if (!req_write) begin
              load_valid <= 1'b1;
              load_data  <= load_ext;
            end else if (subword_store) begin
              rmw_word  <= merged;
              rmw_index <= req_addr[31:2];
              state     <= RMW_WRITE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Self-checking bench for load_store_unit.
//
// A word-addressed memory with a known reset image is attached to the DUT.
// The bench keeps its own reference copy of the memory and computes every
// expected result with plain byte-address arithmetic. Expected registered
// responses are queued when a request is issued. A separate monitor pops
// and compares them whenever the DUT raises a pulse.
module tb_load_store_unit;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;
  logic        out_of_range;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic        mem_ren;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .misaligned   (misaligned),
    .out_of_range (out_of_range),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wen      (mem_wen),
    .mem_ren      (mem_ren),
    .mem_rdata    (mem_rdata)
  );

  // Physical memory seen by the DUT, plus the bench's reference copy.
  logic [31:0] mem    [0:DEPTH-1];
  logic [31:0] refMem [0:DEPTH-1];

  assign mem_rdata = (mem_addr < 32'(DEPTH)) ? mem[mem_addr[9:0]] : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (mem_wen && (mem_addr < 32'(DEPTH)))
      mem[mem_addr[9:0]] <= mem_wdata;
  end

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always @(posedge clk) cycle++;

  typedef struct {
    int          cyc;
    bit          lv;
    logic [31:0] data;
    bit          mis;
    bit          oor;
  } exp_t;

  exp_t        sbq[$];
  exp_t        monEntry;
  logic [31:0] lastData = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
               name, actual, expected, cycle);
    end
  endtask

  // Monitor: compare each registered pulse with the next queued expectation.
  // With no pulse, load_data must keep the last completed load result.
  always @(negedge clk) begin
    if (!reset) begin
      lastData = '0;
    end else if (load_valid || misaligned || out_of_range) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_pulse",
                    {29'b0, load_valid, misaligned, out_of_range}, 32'h0);
      end else begin
        monEntry = sbq.pop_front();
        checkOutput("pulse_cycle", 32'(cycle), 32'(monEntry.cyc));
        checkOutput("load_valid", 32'(load_valid), 32'(monEntry.lv));
        checkOutput("misaligned", 32'(misaligned), 32'(monEntry.mis));
        checkOutput("out_of_range", 32'(out_of_range), 32'(monEntry.oor));
        if (monEntry.lv) begin
          checkOutput("load_data", load_data, monEntry.data);
          lastData = monEntry.data;
        end else begin
          checkOutput("load_data_hold", load_data, lastData);
        end
      end
    end else begin
      checkOutput("load_data_hold", load_data, lastData);
    end
  end

  task automatic idleCycle();
    req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Issue one request. This is called just after a rising edge. It works
  // out the expected behaviour from byte-level rules, checks the
  // combinational strobes, and, for a sub-word store, also checks the
  // write-back cycle.
  task automatic applyStimulus(input bit wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    bit          legal, mis, oor, ok;
    int          size, sh;
    logic [31:0] mask, word, val, idx;

    legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2})
               : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    mis   = legal && ((int'(addr[1:0]) % size) != 0);
    idx   = addr >> 2;
    oor   = legal && !mis && (idx >= 32'(DEPTH));
    ok    = legal && !mis && !oor;
    sh    = 8 * int'(addr[1:0]);
    mask  = (size >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);

    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;

    if (legal && !wr) begin
      val = '0;
      if (ok) begin
        word = refMem[idx];
        val  = (word >> sh) & mask;
        if (!f3[2] && size < 4 && val[8 * size - 1])
          val = val | ~mask;
      end
      sbq.push_back('{cycle + 1, 1'b1, val, mis, oor});
    end else if (legal && wr && !ok) begin
      sbq.push_back('{cycle + 1, 1'b0, 32'h0, mis, oor});
    end

    if (ok && wr)
      refMem[idx] = (refMem[idx] & ~(mask << sh)) | ((wdata & mask) << sh);

    @(negedge clk);
    checkOutput("stall", 32'(stall), 32'(ok && wr && size < 4));
    checkOutput("mem_ren", 32'(mem_ren), 32'(ok && (!wr || size < 4)));
    checkOutput("mem_wen", 32'(mem_wen), 32'(ok && wr && size == 4));
    if (ok)
      checkOutput("mem_addr", mem_addr, idx);
    if (ok && wr && size == 4)
      checkOutput("mem_wdata", mem_wdata, wdata);
    @(posedge clk);
    #1;

    if (ok && wr && size < 4) begin
      @(negedge clk);
      checkOutput("rmw_stall", 32'(stall), 32'h0);
      checkOutput("rmw_wen", 32'(mem_wen), 32'h1);
      checkOutput("rmw_addr", mem_addr, idx);
      checkOutput("rmw_wdata", mem_wdata, refMem[idx]);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rIdx, rAddr;
    int          r;

    for (int i = 0; i < DEPTH; i++) begin
      mem[i]    = (i < 6) ? 32'(70 + i) : $urandom;
      refMem[i] = mem[i];
    end

    // Reset while a word store is presented. Nothing may leak through.
    reset      = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_stall", 32'(stall), 32'h0);
    checkOutput("reset_mem_wen", 32'(mem_wen), 32'h0);
    checkOutput("reset_mem_ren", 32'(mem_ren), 32'h0);
    checkOutput("reset_load_valid", 32'(load_valid), 32'h0);
    checkOutput("reset_misaligned", 32'(misaligned), 32'h0);
    checkOutput("reset_out_of_range", 32'(out_of_range), 32'h0);
    checkOutput("reset_load_data", load_data, 32'h0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = 1'b0;

    // Directed accesses from the memory reset image.
    applyStimulus(1'b0, 3'b010, 32'h8, 32'h0);
    applyStimulus(1'b1, 3'b000, 32'h5, 32'h0000_00AB);
    checkOutput("word1_after_sb", mem[1], 32'h0000_AB47);
    applyStimulus(1'b0, 3'b000, 32'h5, 32'h0);
    applyStimulus(1'b0, 3'b100, 32'h5, 32'h0);
    applyStimulus(1'b1, 3'b001, 32'hA, 32'h0000_8001);
    checkOutput("word2_after_sh", mem[2], 32'h8001_0048);
    applyStimulus(1'b0, 3'b001, 32'hA, 32'h0);
    applyStimulus(1'b0, 3'b101, 32'hA, 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h6, 32'h0);
    applyStimulus(1'b1, 3'b001, 32'h3, 32'h0000_1234);
    checkOutput("word0_after_bad_sh", mem[0], 32'd70);
    applyStimulus(1'b0, 3'b010, 32'h1000, 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h8, 32'h0);
    idleCycle();
    idleCycle();

    // Reset during the read cycle of an sb. The store must never be accepted.
    reset      = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0000_0055;
    @(negedge clk);
    checkOutput("rst_rd_stall", 32'(stall), 32'h0);
    checkOutput("rst_rd_mem_ren", 32'(mem_ren), 32'h0);
    checkOutput("rst_rd_mem_wen", 32'(mem_wen), 32'h0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_after_mem_wen", 32'(mem_wen), 32'h0);
    checkOutput("rst_after_stall", 32'(stall), 32'h0);
    checkOutput("rst_after_load_valid", 32'(load_valid), 32'h0);
    checkOutput("rst_after_load_data", load_data, 32'h0);
    checkOutput("rst_after_misaligned", 32'(misaligned), 32'h0);
    checkOutput("rst_after_out_of_range", 32'(out_of_range), 32'h0);
    @(posedge clk);
    #1;

    // Reset in the write-back cycle of an sb. The pending write is dropped.
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0000_0055;
    @(negedge clk);
    checkOutput("rst_wb_accept_stall", 32'(stall), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_wb_mem_wen", 32'(mem_wen), 32'h0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_wb_idle_mem_wen", 32'(mem_wen), 32'h0);
    checkOutput("rst_wb_idle_stall", 32'(stall), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("word0_after_reset", mem[0], 32'd70);

    // Randomized traffic, concentrated on a few words so that stores and
    // loads collide. A little of it is out of range.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)
        rIdx = 32'(DEPTH) + $urandom_range(0, 7);
      else if (r == 1)
        rIdx = $urandom;
      else
        rIdx = $urandom_range(0, 7);
      rAddr = (rIdx << 2) | 32'($urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    rAddr, $urandom);
      if ($urandom_range(0, 7) == 0)
        idleCycle();
    end

    repeat (3) idleCycle();
    checkOutput("queue_empty", 32'(sbq.size()), 32'h0);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("mem_word%0d", i), mem[i], refMem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the pipeline MEM stage and the word-addressed data memory.
- Converts RISC-V byte-addressed loads and stores (lb/lh/lw/lbu/lhu, sb/sh/sw) into word accesses.
- Sub-word stores run as a two-cycle read-modify-write (RMW) and stall the pipeline for one cycle.
- Load results are registered; misaligned and out-of-range accesses are blocked and flagged.

Parameters:
- DEPTH, 1024, number of 32-bit words in the data memory; valid word index is 0..DEPTH-1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- req_valid  input  1  MEM stage presents a memory instruction.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; low byte/half used for sb/sh.
- stall  output  1  combinational; 1 = pipeline must hold the MEM-stage request unchanged.
- load_data  output  32  registered, extended load result.
- load_valid  output  1  registered one-cycle pulse qualifying load_data.
- misaligned  output  1  registered one-cycle pulse: access blocked for misalignment.
- out_of_range  output  1  registered one-cycle pulse: word index >= DEPTH.
- mem_addr  output  32  word index, req_addr[31:2] zero-extended.
- mem_wdata  output  32  word to write.
- mem_wen  output  1  write strobe; memory writes on posedge.
- mem_ren  output  1  read enable; memory returns mem_rdata combinationally.
- mem_rdata  input  32  word read from memory.

Behaviour:
- FSM states: IDLE, RMW_WRITE.
- Reset (reset=0 at posedge): state IDLE; load_data=0, load_valid=0, misaligned=0, out_of_range=0; rmw_word register=0.
- Reset mid-RMW: any pending RMW write is dropped; the word is never written.
- Combinational outputs stall, mem_wen and mem_ren are 0 while reset=0.
- Misalignment rule: h/hu/sh with addr[0]!=0 is misaligned; w/sw with addr[1:0]!=0 is misaligned.
- Range check: out_of_range when addr[31:2] >= DEPTH. Misalignment has priority over out_of_range.
- Blocked access: mem_wen=0, mem_ren=0, no stall. Next cycle the matching flag pulses. For a blocked load, load_valid=1 with load_data=0.
- Illegal funct3 (011, 110, 111, or 100/101 on a store): no memory access, no flags, no load_valid.
- Load in IDLE: mem_ren=1, mem_addr=word index, stall=0.
  - Next posedge registers load_data and pulses load_valid (latency 1).
  - Byte lane selected by addr[1:0]; half lane by addr[1].
  - b/h: sign-extend to 32 bits; bu/hu: zero-extend; w: word as read.
- sw in IDLE: mem_wen=1, mem_wdata=req_wdata, single cycle, stall=0.
- sb/sh in IDLE (accepted cycle):
  - mem_ren=1, stall=1.
  - rmw_word latches mem_rdata with the addressed byte/half replaced by req_wdata[7:0] / [15:0].
  - Next state RMW_WRITE.
- RMW_WRITE:
  - mem_wen=1, mem_wdata=rmw_word, mem_addr from the held request, stall=0.
  - req_valid is ignored (same held store).
  - Returns to IDLE.
- A load issued the cycle after RMW_WRITE sees the updated word.
- req_valid=0 in IDLE: no access; registered pulses return to 0.
- load_data holds its last value when no load completes.

Test Plan:
- Memory reset image words 0..5 = 70..75. lw addr 0x8 -> mem_ren=1, stall=0; next cycle load_valid=1, load_data=72.
- sb addr 0x5, wdata 0x000000AB -> stall=1 for one cycle, then mem_wen=1 with word1 = 0x0000AB47. Follow-up checks:
  - lb 0x5 -> load_data=0xFFFFFFAB.
  - lbu 0x5 -> load_data=0x000000AB.
- sh addr 0xA, wdata 0x00008001 -> word2 = 0x80010048. Follow-up checks:
  - lh 0xA -> load_data=0xFFFF8001.
  - lhu 0xA -> load_data=0x00008001.
- Misaligned accesses:
  - lw addr 0x6 -> no mem_ren/mem_wen; next cycle misaligned=1, load_valid=1, load_data=0.
  - sh addr 0x3 -> misaligned=1, no stall; word0 stays 70.
- lw addr 0x1000 (word 1024) -> out_of_range=1, no access.
- sb addr 0x0: drive reset=0 during the RMW read cycle -> state IDLE, mem_wen never asserts, word0 stays 70, all registered outputs 0.
